// File: rtl/gray_cnt_pkg.sv
// Shared definitions for the Gray-code counter: direction encodings, the widest supported
// code and the binary<->Gray conversion helpers. The helpers work on MaxWidth-bit values;
// narrower codes are zero-extended in and truncated out, which is exact for both directions.
package gray_cnt_pkg;

  localparam int unsigned MaxWidth = 32;

  localparam logic DirUp = 1'b1;
  localparam logic DirDn = 1'b0;

  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down, the same decode gr_bin performs.
  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] g);
    logic [MaxWidth-1:0] b;
    b[MaxWidth-1] = g[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_cnt_if.sv
// Counter control/status bundle.
//   master: drives en, up_dn, rdy, load, load_bin; observes gray_out, bin_out, vld, wrap,
//           at_end (and err when GRAY_CNT_CHECK_EN is defined).
//   slave : the counter side of the same signals.
interface gray_cnt_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             up_dn;
  logic             rdy;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             vld;
  logic             wrap;
  logic             at_end;
`ifdef GRAY_CNT_CHECK_EN
  logic             err;

  modport master (
    output en, up_dn, rdy, load, load_bin,
    input  gray_out, bin_out, vld, wrap, at_end, err
  );
  modport slave (
    input  en, up_dn, rdy, load, load_bin,
    output gray_out, bin_out, vld, wrap, at_end, err
  );
`else
  modport master (
    output en, up_dn, rdy, load, load_bin,
    input  gray_out, bin_out, vld, wrap, at_end
  );
  modport slave (
    input  en, up_dn, rdy, load, load_bin,
    output gray_out, bin_out, vld, wrap, at_end
  );
`endif
endinterface

// File: rtl/gray_cnt_core.sv
// Binary count register with next-value mux and wrap/saturate handling.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en, up_dn, rdy      step request, direction (1 = up), downstream ready
//   load, load_bin      synchronous load (beats a step) and its value
//   bin                 registered binary count
//   next_bin            value bin takes at the coming edge
//   changed             a load or an effective step happens at the coming edge
//   wrap                registered pulse: the last step crossed max->0 or 0->max
//   at_end              combinational: count sits at the end of the range for up_dn
module gray_cnt_core
  import gray_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             rdy,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] next_bin,
  output logic             changed,
  output logic             wrap,
  output logic             at_end
);

  localparam logic [WIDTH-1:0] MaxCount = '1;
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic             wrap_q, wrap_d;
  logic             step, do_step;

  assign at_end  = (up_dn == DirUp) ? (bin_q == MaxCount) : (bin_q == '0);
  assign step    = en & rdy & ~load;
  // In saturate mode a step that would cross the end is dropped entirely.
  assign do_step = step & ~(SAT & at_end);
  assign wrap_d  = do_step & at_end;
  assign changed = load | do_step;

  always_comb begin
    next_bin = bin_q;
    if (load) begin
      next_bin = load_bin;
    end else if (do_step) begin
      next_bin = (up_dn == DirUp) ? bin_q + One : bin_q - One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= next_bin;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/gray_cnt.sv
// Registered up/down Gray-code counter feeding gr_bin.din, with a binary shadow count.
// gray_out and bin_out update on the same edge; vld pulses on any load or step.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          gray_cnt_if.slave: en, up_dn, rdy, load, load_bin in;
//                gray_out, bin_out, vld, wrap, at_end out
// Optional feature, macro GRAY_CNT_CHECK_EN: adds sticky bus.err, set when a step moves
// gray_out by other than exactly one bit, or when gray_out does not decode to bin_out.
module gray_cnt
  import gray_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter bit          SAT   = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  gray_cnt_if.slave   bus
);

  logic [WIDTH-1:0] bin_q, next_bin, gray_d, gray_q;
  logic             changed, wrap_q, at_end, vld_q;

  gray_cnt_core #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .up_dn    (bus.up_dn),
    .rdy      (bus.rdy),
    .load     (bus.load),
    .load_bin (bus.load_bin),
    .bin      (bin_q),
    .next_bin (next_bin),
    .changed  (changed),
    .wrap     (wrap_q),
    .at_end   (at_end)
  );

  // Encode the next binary value so the Gray register lands on the same edge as bin.
  assign gray_d = WIDTH'(bin2gray(MaxWidth'(next_bin)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      gray_q <= gray_d;
      vld_q  <= changed;
    end
  end

  assign bus.gray_out = gray_q;
  assign bus.bin_out  = bin_q;
  assign bus.vld      = vld_q;
  assign bus.wrap     = wrap_q;
  assign bus.at_end   = at_end;

`ifdef GRAY_CNT_CHECK_EN
  logic [WIDTH-1:0] gray_prev_q;
  logic             step_q, err_q, err_d, one_bit_bad, decode_bad;

  always_comb begin
    // Loads may legitimately flip several bits, so only steps are checked for distance.
    one_bit_bad = step_q && ($countones(gray_q ^ gray_prev_q) != 1);
    decode_bad  = gray2bin(MaxWidth'(gray_q)) != MaxWidth'(bin_q);
    err_d       = err_q | one_bit_bad | decode_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_prev_q <= '0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gray_prev_q <= gray_q;
      step_q      <= changed & ~bus.load;
      err_q       <= err_d;
    end
  end

  assign bus.err = err_q;
`endif

endmodule
